reservation_station_bank: RTL

- Multi-entry, parametrised successor to the single-entry reservation station. It holds up to RS_DEPTH dispatched instructions between dispatch/ROB and the ALU.
- Each entry captures operands from dispatch or from the CDB (Common Data Bus) and wakes up when both operands are valid.
- Each cycle it offers the oldest ready entry to the functional unit through a valid/ack handshake.
- It supports a full flush when the ROB (reorder buffer) clears.

---
 rtl/reservation_station_bank_if.sv | 63 ++++++
 rtl/reservation_station_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_bank_if.sv
// Dispatch / CDB / issue bundle for reservation_station_bank.
//   master : the dispatch stage, CDB and FU side (drives loads, broadcasts and acks)
//   slave  : the reservation station bank (drives availability and the issue offer)
// Operand fields hold a value when *_valid=1, otherwise the low TAG_BITS hold
// the ROB tag of the producing instruction.
`ifndef ROB_TAG_BITS
`define ROB_TAG_BITS 5
`endif

interface reservation_station_bank_if #(
  parameter int RS_DEPTH = 4,
  parameter int XLEN     = 32,
  parameter int TAG_BITS = `ROB_TAG_BITS,
  parameter int ALU_W    = 5
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // dispatch
  logic                rs_load_in;
  logic [XLEN-1:0]     rs_npc_in;
  logic [XLEN-1:0]     rs_inst_in;
  logic [ALU_W-1:0]    rs_alu_func_in;
  logic [TAG_BITS-1:0] rs_rob_tag;
  logic [XLEN-1:0]     rs_opa_in;
  logic [XLEN-1:0]     rs_opb_in;
  logic                rs_opa_valid;
  logic                rs_opb_valid;
  // common data bus
  logic                rs_cdb_valid;
  logic [TAG_BITS-1:0] rs_cdb_tag;
  logic [XLEN-1:0]     rs_cdb_in;
  // control
  logic                rs_clear;
  logic                rs_issue_ack;
  // status / issue offer
  logic                rs_avail_out;
  logic [CNT_W-1:0]    rs_free_count;
  logic                rs_issue_valid;
  logic [IDX_W-1:0]    rs_issue_idx;
  logic [XLEN-1:0]     rs_opa_out;
  logic [XLEN-1:0]     rs_opb_out;
  logic [TAG_BITS-1:0] rs_tag_out;
  logic [ALU_W-1:0]    rs_alu_func_out;
  logic [XLEN-1:0]     rs_npc_out;
  logic [XLEN-1:0]     rs_inst_out;

  modport master (
    output rs_load_in, rs_npc_in, rs_inst_in, rs_alu_func_in, rs_rob_tag,
           rs_opa_in, rs_opb_in, rs_opa_valid, rs_opb_valid,
           rs_cdb_valid, rs_cdb_tag, rs_cdb_in, rs_clear, rs_issue_ack,
    input  rs_avail_out, rs_free_count, rs_issue_valid, rs_issue_idx,
           rs_opa_out, rs_opb_out, rs_tag_out, rs_alu_func_out, rs_npc_out, rs_inst_out
  );

  modport slave (
    input  rs_load_in, rs_npc_in, rs_inst_in, rs_alu_func_in, rs_rob_tag,
           rs_opa_in, rs_opb_in, rs_opa_valid, rs_opb_valid,
           rs_cdb_valid, rs_cdb_tag, rs_cdb_in, rs_clear, rs_issue_ack,
    output rs_avail_out, rs_free_count, rs_issue_valid, rs_issue_idx,
           rs_opa_out, rs_opb_out, rs_tag_out, rs_alu_func_out, rs_npc_out, rs_inst_out
  );
endinterface

// File: rtl/reservation_station_bank.sv
// Multi-entry reservation station between dispatch/ROB and one ALU.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   bus (slave)    : dispatch load, CDB broadcast, clear, issue offer/ack
// Entries capture operands at dispatch or from the CDB, wake when both are
// valid, and the oldest ready entry (largest age, lowest index on ties) is
// offered to the FU. All outputs come from registered state only.
`ifndef ROB_TAG_BITS
`define ROB_TAG_BITS 5
`endif

// One station slot: holds an instruction, snoops the CDB, ages while occupied.
module rs_entry_slot #(
  parameter int XLEN     = 32,
  parameter int TAG_BITS = 5,
  parameter int AGE_BITS = 4,
  parameter int ALU_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic                free,
  input  logic [XLEN-1:0]     npc_in,
  input  logic [XLEN-1:0]     inst_in,
  input  logic [ALU_W-1:0]    func_in,
  input  logic [TAG_BITS-1:0] tag_in,
  input  logic [XLEN-1:0]     opa_in,
  input  logic [XLEN-1:0]     opb_in,
  input  logic                opa_v_in,
  input  logic                opb_v_in,
  input  logic                cdb_valid,
  input  logic [TAG_BITS-1:0] cdb_tag,
  input  logic [XLEN-1:0]     cdb_in,
  output logic                in_use,
  output logic                ready,
  output logic [AGE_BITS-1:0] age,
  output logic [XLEN-1:0]     opa,
  output logic [XLEN-1:0]     opb,
  output logic [XLEN-1:0]     npc,
  output logic [XLEN-1:0]     inst,
  output logic [TAG_BITS-1:0] tag,
  output logic [ALU_W-1:0]    func
);
  typedef struct packed {
    logic                in_use;
    logic                opa_v;
    logic                opb_v;
    logic [XLEN-1:0]     opa;
    logic [XLEN-1:0]     opb;
    logic [XLEN-1:0]     npc;
    logic [XLEN-1:0]     inst;
    logic [TAG_BITS-1:0] tag;
    logic [ALU_W-1:0]    func;
    logic [AGE_BITS-1:0] age;
  } ent_t;

  ent_t ent_q, ent_d;

  // stored-operand wakeup and dispatch-time bypass hits
  logic a_hit, b_hit, da_hit, db_hit;
  assign a_hit  = !ent_q.opa_v && cdb_valid && (ent_q.opa[TAG_BITS-1:0] == cdb_tag);
  assign b_hit  = !ent_q.opb_v && cdb_valid && (ent_q.opb[TAG_BITS-1:0] == cdb_tag);
  assign da_hit = !opa_v_in    && cdb_valid && (opa_in[TAG_BITS-1:0] == cdb_tag);
  assign db_hit = !opb_v_in    && cdb_valid && (opb_in[TAG_BITS-1:0] == cdb_tag);

  always_comb begin
    ent_d = ent_q;
    if (ent_q.in_use) begin
      if (a_hit) begin ent_d.opa = cdb_in; ent_d.opa_v = 1'b1; end
      if (b_hit) begin ent_d.opb = cdb_in; ent_d.opb_v = 1'b1; end
      if (ent_q.age != '1) ent_d.age = ent_q.age + 1'b1;
    end
    if (free) begin
      ent_d.in_use = 1'b0;
      ent_d.age    = '0;
    end
    // load only targets a slot that was free, so it never collides with free
    if (load) begin
      ent_d.in_use = 1'b1;
      ent_d.opa_v  = opa_v_in || da_hit;
      ent_d.opb_v  = opb_v_in || db_hit;
      ent_d.opa    = da_hit ? cdb_in : opa_in;
      ent_d.opb    = db_hit ? cdb_in : opb_in;
      ent_d.npc    = npc_in;
      ent_d.inst   = inst_in;
      ent_d.tag    = tag_in;
      ent_d.func   = func_in;
      ent_d.age    = '0;
    end
    if (clear) begin
      ent_d.in_use = 1'b0;
      ent_d.age    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign in_use = ent_q.in_use;
  assign ready  = ent_q.in_use && ent_q.opa_v && ent_q.opb_v;
  assign age    = ent_q.age;
  assign opa    = ent_q.opa;
  assign opb    = ent_q.opb;
  assign npc    = ent_q.npc;
  assign inst   = ent_q.inst;
  assign tag    = ent_q.tag;
  assign func   = ent_q.func;
endmodule

module reservation_station_bank #(
  parameter int RS_DEPTH = 4,
  parameter int XLEN     = 32,
  parameter int TAG_BITS = `ROB_TAG_BITS,
  parameter int AGE_BITS = 4,
  parameter int ALU_W    = 5
) (
  input logic clock,
  input logic reset,
  reservation_station_bank_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]                in_use, ready, load_vec, free_vec;
  logic [RS_DEPTH-1:0][AGE_BITS-1:0]  age;
  logic [RS_DEPTH-1:0][XLEN-1:0]      opa, opb, npc, inst;
  logic [RS_DEPTH-1:0][TAG_BITS-1:0]  tag;
  logic [RS_DEPTH-1:0][ALU_W-1:0]     func;

  logic [CNT_W-1:0]    free_cnt;
  logic [IDX_W-1:0]    alloc_idx, sel_idx;
  logic [AGE_BITS-1:0] best_age;
  logic                sel_vld, load_fire, ack_fire;

  // free count and lowest free index (descending scan leaves the lowest)
  always_comb begin
    free_cnt  = '0;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        free_cnt  = free_cnt + 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // oldest ready entry; strict '>' keeps the lowest index on equal ages
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    best_age = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready[i] && (!sel_vld || age[i] > best_age)) begin
        sel_vld  = 1'b1;
        sel_idx  = IDX_W'(i);
        best_age = age[i];
      end
    end
  end

  assign load_fire = bus.rs_load_in && (free_cnt != '0);
  assign ack_fire  = bus.rs_issue_ack && sel_vld;

  // allocation uses start-of-cycle occupancy, so an acked slot is not reused
  // in the same cycle
  always_comb begin
    load_vec = '0;
    free_vec = '0;
    if (load_fire) load_vec[alloc_idx] = 1'b1;
    if (ack_fire)  free_vec[sel_idx]   = 1'b1;
  end

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_ent
    rs_entry_slot #(
      .XLEN(XLEN), .TAG_BITS(TAG_BITS), .AGE_BITS(AGE_BITS), .ALU_W(ALU_W)
    ) u_ent (
      .clock    (clock),
      .reset    (reset),
      .clear    (bus.rs_clear),
      .load     (load_vec[g]),
      .free     (free_vec[g]),
      .npc_in   (bus.rs_npc_in),
      .inst_in  (bus.rs_inst_in),
      .func_in  (bus.rs_alu_func_in),
      .tag_in   (bus.rs_rob_tag),
      .opa_in   (bus.rs_opa_in),
      .opb_in   (bus.rs_opb_in),
      .opa_v_in (bus.rs_opa_valid),
      .opb_v_in (bus.rs_opb_valid),
      .cdb_valid(bus.rs_cdb_valid),
      .cdb_tag  (bus.rs_cdb_tag),
      .cdb_in   (bus.rs_cdb_in),
      .in_use   (in_use[g]),
      .ready    (ready[g]),
      .age      (age[g]),
      .opa      (opa[g]),
      .opb      (opb[g]),
      .npc      (npc[g]),
      .inst     (inst[g]),
      .tag      (tag[g]),
      .func     (func[g])
    );
  end

  assign bus.rs_avail_out    = (free_cnt != '0);
  assign bus.rs_free_count   = free_cnt;
  assign bus.rs_issue_valid  = sel_vld;
  assign bus.rs_issue_idx    = sel_idx;
  assign bus.rs_opa_out      = sel_vld ? opa[sel_idx]  : '0;
  assign bus.rs_opb_out      = sel_vld ? opb[sel_idx]  : '0;
  assign bus.rs_tag_out      = sel_vld ? tag[sel_idx]  : '0;
  assign bus.rs_alu_func_out = sel_vld ? func[sel_idx] : '0;
  assign bus.rs_npc_out      = sel_vld ? npc[sel_idx]  : '0;
  assign bus.rs_inst_out     = sel_vld ? inst[sel_idx] : '0;
endmodule
